// File: rtl/sqrt_datapath.sv
// Register/ALU datapath for the square-root unit: R1..R5, two arithmetic units with
// operand muxes, status flags back to the controller, and result capture on Done.
module sqrt_datapath #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] data_in,
   input  logic             en_R1,
   input  logic             en_R2,
   input  logic             en_R3,
   input  logic             en_R4,
   input  logic             en_R5,
   input  logic             bus1,
   input  logic [1:0]       bus2,
   input  logic [1:0]       bus3,
   input  logic [1:0]       bus4,
   input  logic [1:0]       bus5,
   input  logic             bus6,
   input  logic [1:0]       bus7,
   input  logic [1:0]       sel_AU1,
   input  logic [1:0]       sel_AU2,
   input  logic             Done,
   output logic             flag_neg,
   output logic             flag_zero,
   output logic [WIDTH-1:0] result,
   output logic             result_valid,
   output logic             busy
);

   logic [WIDTH-1:0] r1_q, r2_q, r3_q, r4_q, r5_q;
   logic [WIDTH-1:0] r1_d, r2_d, r345_d;
   logic [WIDTH-1:0] au1_a, au1_b, au1_y;
   logic [WIDTH-1:0] au2_a, au2_b, au2_y;
   logic             flag_neg_q, flag_neg_d;
   logic             flag_zero_q, flag_zero_d;
   logic [WIDTH-1:0] result_q;
   logic             result_valid_q;
   logic             busy_q, busy_d;
   logic             done_q;
   logic             done_rise;
   logic             any_en;

   // AU1 operand muxes and operation
   always_comb begin
      au1_a = '0;
      au1_b = '0;
      au1_y = '0;
      case (bus2)
         2'b00:   au1_a = r1_q;
         2'b01:   au1_a = r2_q;
         2'b10:   au1_a = r3_q;
         default: au1_a = data_in;
      endcase
      case (bus3)
         2'b00:   au1_b = r2_q;
         2'b01:   au1_b = r4_q;
         2'b10:   au1_b = WIDTH'(1);
         default: au1_b = '0;
      endcase
      case (sel_AU1)
         2'b00:   au1_y = au1_a + au1_b;
         2'b01:   au1_y = au1_a - au1_b;
         2'b10:   au1_y = au1_a + WIDTH'(1);
         default: au1_y = au1_a;
      endcase
   end

   // AU2 operand muxes and operation
   always_comb begin
      au2_a = '0;
      au2_b = '0;
      au2_y = '0;
      case (bus4)
         2'b00:   au2_a = r3_q;
         2'b01:   au2_a = r4_q;
         2'b10:   au2_a = r5_q;
         default: au2_a = r1_q;
      endcase
      case (bus5)
         2'b00:   au2_b = r5_q;
         2'b01:   au2_b = WIDTH'(1);
         2'b10:   au2_b = r2_q;
         default: au2_b = '0;
      endcase
      case (sel_AU2)
         2'b00:   au2_y = au2_a + au2_b;
         2'b01:   au2_y = au2_a - au2_b;
         2'b10:   au2_y = {au2_a[WIDTH-2:0], 1'b0};
         default: au2_y = au2_b;
      endcase
   end

   // Write-source selection; R3/R4/R5 share one source
   always_comb begin
      r1_d   = bus1 ? au2_y : au1_y;
      r2_d   = bus6 ? au2_y : au1_y;
      r345_d = '0;
      case (bus7)
         2'b00:   r345_d = au1_y;
         2'b01:   r345_d = au2_y;
         2'b10:   r345_d = data_in;
         default: r345_d = '0;
      endcase
   end

   assign flag_neg_d  = (sel_AU1 == 2'b01) && (au1_a < au1_b);
   assign flag_zero_d = (au1_y == '0);
   assign done_rise   = Done & ~done_q;
   assign any_en      = en_R1 | en_R2 | en_R3 | en_R4 | en_R5;

   // Clearing on the result pulse takes priority over a new start
   always_comb begin
      busy_d = busy_q;
      if (done_rise)
         busy_d = 1'b0;
      else if (any_en && !busy_q)
         busy_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r1_q           <= '0;
         r2_q           <= '0;
         r3_q           <= '0;
         r4_q           <= '0;
         r5_q           <= '0;
         flag_neg_q     <= 1'b0;
         flag_zero_q    <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
      end else begin
         if (en_R1) r1_q <= r1_d;
         if (en_R2) r2_q <= r2_d;
         if (en_R3) r3_q <= r345_d;
         if (en_R4) r4_q <= r345_d;
         if (en_R5) r5_q <= r345_d;
         flag_neg_q     <= flag_neg_d;
         flag_zero_q    <= flag_zero_d;
         done_q         <= Done;
         result_valid_q <= done_rise;
         if (done_rise) result_q <= r3_q;
         busy_q         <= busy_d;
      end
   end

   // result_valid is a single-cycle pulse with no back-pressure; result is stable
   // from that pulse until the next rising edge of Done.
   assign flag_neg     = flag_neg_q;
   assign flag_zero    = flag_zero_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_sqrt_datapath.sv
// Self-checking bench for sqrt_datapath: directed scenarios plus a result scoreboard.
module tb_sqrt_datapath;

   localparam int W = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [W-1:0]  data_in;
   logic          en_R1, en_R2, en_R3, en_R4, en_R5;
   logic          bus1, bus6;
   logic [1:0]    bus2, bus3, bus4, bus5, bus7;
   logic [1:0]    sel_AU1, sel_AU2;
   logic          Done;
   logic          flag_neg, flag_zero;
   logic [W-1:0]  result;
   logic          result_valid;
   logic          busy;

   int            checks = 0;
   int            failures = 0;
   int            valid_cnt = 0;
   logic [W-1:0]  exp_q[$];

   sqrt_datapath #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .data_in(data_in),
      .en_R1(en_R1), .en_R2(en_R2), .en_R3(en_R3), .en_R4(en_R4), .en_R5(en_R5),
      .bus1(bus1), .bus2(bus2), .bus3(bus3), .bus4(bus4), .bus5(bus5),
      .bus6(bus6), .bus7(bus7), .sel_AU1(sel_AU1), .sel_AU2(sel_AU2),
      .Done(Done), .flag_neg(flag_neg), .flag_zero(flag_zero),
      .result(result), .result_valid(result_valid), .busy(busy)
   );

   // clock
   always #5 clk = ~clk;

   // scoreboard: every result_valid pulse must match the oldest expected result
   always @(negedge clk) begin
      if (rst_n && result_valid) begin
         valid_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected_valid: result=%h, no result expected", result);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            if (result !== e) begin
               failures++;
               $display("FAIL sb_result: got %h expected %h", result, e);
            end
         end
      end
   end

   function automatic logic [W-1:0] m_au1(input logic [W-1:0] a, b, input logic [1:0] s);
      case (s)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a + 16'd1;
         default: return a;
      endcase
   endfunction

   function automatic logic [W-1:0] m_au2(input logic [W-1:0] a, b, input logic [1:0] s);
      case (s)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a * 16'd2;
         default: return b;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_ctrl();
      data_in = '0;
      en_R1 = 0; en_R2 = 0; en_R3 = 0; en_R4 = 0; en_R5 = 0;
      bus1 = 0; bus6 = 0; bus2 = 0; bus3 = 0; bus4 = 0; bus5 = 0; bus7 = 0;
      sel_AU1 = 0; sel_AU2 = 0; Done = 0;
   endtask

   task automatic load_reg(input int k, input logic [W-1:0] v);
      idle_ctrl();
      data_in = v;
      case (k)
         1: begin bus2 = 2'd3; sel_AU1 = 2'd3; bus1 = 0; en_R1 = 1; end
         2: begin bus2 = 2'd3; sel_AU1 = 2'd3; bus6 = 0; en_R2 = 1; end
         3: begin bus7 = 2'd2; en_R3 = 1; end
         4: begin bus7 = 2'd2; en_R4 = 1; end
         default: begin bus7 = 2'd2; en_R5 = 1; end
      endcase
      step();
      idle_ctrl();
   endtask

   task automatic test_reset();
      idle_ctrl();
      #1 rst_n = 0;
      #2;
      checks++;
      if ({flag_neg, flag_zero, result, result_valid, busy} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got neg=%b zero=%b res=%h v=%b busy=%b required all 0",
                  flag_neg, flag_zero, result, result_valid, busy);
      end
      checks++;
      if ({dut.r1_q, dut.r2_q, dut.r3_q, dut.r4_q, dut.r5_q} !== '0) begin
         failures++;
         $display("FAIL reset_regs: registers not cleared");
      end
      step(); step();
      rst_n = 1;
      step();
   endtask

   task automatic test_load();
      idle_ctrl();
      data_in = 16'd49; en_R1 = 1; bus1 = 0; bus2 = 2'd3; sel_AU1 = 2'd3;
      step();
      idle_ctrl();
      checks++;
      if (dut.r1_q !== 16'd49) begin
         failures++; $display("FAIL load_r1: got %0d required 49", dut.r1_q);
      end
      checks++;
      if (flag_neg !== 1'b0 || flag_zero !== 1'b0) begin
         failures++; $display("FAIL load_flags: neg=%b zero=%b required 0 0", flag_neg, flag_zero);
      end
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL load_busy: got %b required 1", busy);
      end
   endtask

   task automatic test_sub_borrow();
      load_reg(1, 16'd5);
      load_reg(2, 16'd7);
      bus2 = 2'd0; bus3 = 2'd0; sel_AU1 = 2'd1; en_R1 = 1; bus1 = 0;
      step();
      idle_ctrl();
      checks++;
      if (dut.r1_q !== 16'hFFFE) begin
         failures++; $display("FAIL sub_r1: got %h required fffe", dut.r1_q);
      end
      checks++;
      if (flag_neg !== 1'b1 || flag_zero !== 1'b0) begin
         failures++; $display("FAIL sub_flags: neg=%b zero=%b required 1 0", flag_neg, flag_zero);
      end
   endtask

   task automatic test_zero_wrap();
      load_reg(1, 16'd7);
      load_reg(2, 16'd7);
      load_reg(5, 16'hFFFF);
      load_reg(4, 16'h1234);
      bus2 = 2'd0; bus3 = 2'd0; sel_AU1 = 2'd1; en_R1 = 1; bus1 = 0;
      bus4 = 2'd2; bus5 = 2'd1; sel_AU2 = 2'd0; bus7 = 2'd1; en_R4 = 1;
      step();
      idle_ctrl();
      checks++;
      if (dut.r1_q !== 16'd0 || flag_zero !== 1'b1 || flag_neg !== 1'b0) begin
         failures++;
         $display("FAIL zero_sub: r1=%h zero=%b neg=%b required 0 1 0", dut.r1_q, flag_zero, flag_neg);
      end
      checks++;
      if (dut.r4_q !== 16'd0) begin
         failures++; $display("FAIL wrap_au2: r4=%h required 0", dut.r4_q);
      end
   endtask

   task automatic test_shared_bus7();
      load_reg(4, 16'd3);
      load_reg(3, 16'd100);
      load_reg(5, 16'd200);
      bus4 = 2'd1; sel_AU2 = 2'd2; bus7 = 2'd1; en_R3 = 1; en_R5 = 1;
      step();
      idle_ctrl();
      checks++;
      if (dut.r3_q !== 16'd6 || dut.r5_q !== 16'd6 || dut.r4_q !== 16'd3) begin
         failures++;
         $display("FAIL bus7_shared: r3=%0d r4=%0d r5=%0d required 6 3 6", dut.r3_q, dut.r4_q, dut.r5_q);
      end
      // R4 feeds AU2 while all three are written: old R4 is used
      bus4 = 2'd1; sel_AU2 = 2'd2; bus7 = 2'd1; en_R3 = 1; en_R4 = 1; en_R5 = 1;
      step();
      idle_ctrl();
      checks++;
      if (dut.r3_q !== 16'd6 || dut.r4_q !== 16'd6 || dut.r5_q !== 16'd6) begin
         failures++;
         $display("FAIL bus7_rbw: r3=%0d r4=%0d r5=%0d required 6 6 6", dut.r3_q, dut.r4_q, dut.r5_q);
      end
   endtask

   task automatic test_done();
      int v0;
      load_reg(3, 16'd7);
      v0 = valid_cnt;
      Done = 1;
      exp_q.push_back(16'd7);
      step();
      checks++;
      if (result !== 16'd7 || result_valid !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL done_first: res=%0d v=%b busy=%b required 7 1 0", result, result_valid, busy);
      end
      step();
      checks++;
      if (result_valid !== 1'b0 || result !== 16'd7) begin
         failures++; $display("FAIL done_held: v=%b res=%0d required 0 7", result_valid, result);
      end
      step();
      Done = 0;
      step();
      checks++;
      if (valid_cnt - v0 !== 1) begin
         failures++; $display("FAIL done_pulses: got %0d required 1", valid_cnt - v0);
      end
      load_reg(3, 16'd11);
      checks++;
      if (busy !== 1'b1) begin
         failures++; $display("FAIL busy_set: got %b required 1", busy);
      end
      data_in = 16'd22; bus7 = 2'd2; en_R3 = 1; Done = 1;
      exp_q.push_back(16'd11);
      step();
      idle_ctrl();
      checks++;
      if (result !== 16'd11 || dut.r3_q !== 16'd22 || busy !== 1'b0) begin
         failures++;
         $display("FAIL done_rbw: res=%0d r3=%0d busy=%b required 11 22 0", result, dut.r3_q, busy);
      end
      step();
   endtask

   task automatic test_reset_mid();
      int v0;
      load_reg(1, 16'd1);
      load_reg(2, 16'd2);
      bus2 = 2'd0; bus3 = 2'd0; sel_AU1 = 2'd1;
      step();
      checks++;
      if (flag_neg !== 1'b1 || busy !== 1'b1 || result === 16'd0) begin
         failures++;
         $display("FAIL pre_reset_state: neg=%b busy=%b res=%h required 1 1 nonzero", flag_neg, busy, result);
      end
      v0 = valid_cnt;
      #2 rst_n = 0;
      #1;
      checks++;
      if ({flag_neg, flag_zero, result, result_valid, busy} !== '0 || dut.r1_q !== '0) begin
         failures++;
         $display("FAIL reset_mid: neg=%b zero=%b res=%h v=%b busy=%b required all 0",
                  flag_neg, flag_zero, result, result_valid, busy);
      end
      idle_ctrl();
      #1 rst_n = 1;
      step(); step(); step();
      checks++;
      if (valid_cnt !== v0 || result !== 16'd0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL post_reset: pulses=%0d res=%h busy=%b required 0 0 0", valid_cnt - v0, result, busy);
      end
   endtask

   task automatic test_random_au();
      logic [W-1:0] r[1:5];
      logic [W-1:0] a1, b1, a2, b2, y1, y2, din;
      for (int it = 0; it < 8; it++) begin
         for (int k = 1; k <= 5; k++) begin
            r[k] = W'($urandom_range(0, 65535));
            load_reg(k, r[k]);
         end
         din = W'($urandom_range(0, 65535));
         data_in = din;
         bus2 = 2'($urandom_range(0, 3)); bus3 = 2'($urandom_range(0, 3));
         bus4 = 2'($urandom_range(0, 3)); bus5 = 2'($urandom_range(0, 3));
         sel_AU1 = 2'($urandom_range(0, 3)); sel_AU2 = 2'($urandom_range(0, 3));
         a1 = (bus2 == 0) ? r[1] : (bus2 == 1) ? r[2] : (bus2 == 2) ? r[3] : din;
         b1 = (bus3 == 0) ? r[2] : (bus3 == 1) ? r[4] : (bus3 == 2) ? 16'd1 : 16'd0;
         a2 = (bus4 == 0) ? r[3] : (bus4 == 1) ? r[4] : (bus4 == 2) ? r[5] : r[1];
         b2 = (bus5 == 0) ? r[5] : (bus5 == 1) ? 16'd1 : (bus5 == 2) ? r[2] : 16'd0;
         y1 = m_au1(a1, b1, sel_AU1);
         y2 = m_au2(a2, b2, sel_AU2);
         bus1 = 0; en_R1 = 1; bus6 = 1; en_R2 = 1;
         step();
         checks++;
         if (dut.r1_q !== y1 || dut.r2_q !== y2) begin
            failures++;
            $display("FAIL rand_au it%0d: r1=%h r2=%h required %h %h", it, dut.r1_q, dut.r2_q, y1, y2);
         end
         checks++;
         if (flag_neg !== (sel_AU1 == 2'd1 && a1 < b1) || flag_zero !== (y1 == 16'd0)) begin
            failures++;
            $display("FAIL rand_flags it%0d: neg=%b zero=%b", it, flag_neg, flag_zero);
         end
         idle_ctrl();
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] v;
      for (int it = 0; it < 6; it++) begin
         v = W'($urandom_range(1, 65535));
         load_reg(3, v);
         Done = 1;
         exp_q.push_back(v);
         repeat ($urandom_range(1, 3)) step();
         Done = 0;
         step();
      end
      step();
      checks++;
      if (exp_q.size() != 0) begin
         failures++; $display("FAIL sb_leftover: %0d results never produced", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_sub_borrow();
      test_zero_wrap();
      test_shared_bus7();
      test_done();
      test_reset_mid();
      test_random_au();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
